alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer that acts as the driving side of the combinational ALU (aluOp encoding 00 add, 01 pass-B, 10 add-and-clear-bit0, 11 subtract).
- Accepts one decoded instruction from the IDU over valid/ready and latches its operands.
- Drives the ALU's operand and opcode inputs and captures the ALU result.
- Presents the registered result to the WBU over valid/ready.

Parameters:
- WIDTH, 32, datapath width of PC, operands and result.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  IDU has a decoded instruction
- in_ready  out  1  block can accept an instruction
- in_pc  in  WIDTH  instruction PC
- in_rs1  in  WIDTH  register source 1 value
- in_rs2  in  WIDTH  register source 2 value
- in_imm  in  WIDTH  sign-extended immediate
- in_opa_sel  in  1  0: A=rs1, 1: A=pc
- in_opb_sel  in  1  0: B=rs2, 1: B=imm
- in_alu_op  in  2  ALU opcode, forwarded unchanged
- in_rd  in  5  destination register index
- in_wen  in  1  register write enable
- in_link  in  1  1: writeback value is pc+4 (jal/jalr)
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_op  out  2  ALU opcode
- alu_out  in  WIDTH  combinational ALU result
- out_valid  out  1  result available to WBU
- out_ready  in  1  WBU accepts result
- out_result  out  WIDTH  writeback value
- out_target  out  WIDTH  raw ALU result (jump target / address)
- out_zero  out  1  alu_out == 0 at capture
- out_rd  out  5  destination index
- out_wen  out  1  write enable, forced 0 when out_rd == 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the clk rising edge.
- FSM states:
  - IDLE: in_ready=1; on fire (in_valid&&in_ready) → EXEC.
  - EXEC: in_ready=0; capture alu_out into the output registers; → DONE.
  - DONE: out_valid=1; on out_ready → IDLE, or → EXEC if in_valid is also 1 (back-to-back accept).
- in_ready = (state==IDLE) || (state==DONE && out_ready). Purely combinational, with no dependence on in_valid.
- Operands are latched on fire. alu_a/alu_b/alu_op are driven from the latches only in EXEC; in IDLE and DONE they are 0/0/2'b00.
- Latency: fire at edge N → EXEC during cycle N+1 → out_valid high from cycle N+2. Throughput is 1 result per 2 cycles with out_ready held high.
- Capture in EXEC:
  - out_target = alu_out
  - out_zero = (alu_out == 0)
  - out_result = in_link ? pc+4 : alu_out
  - pc+4 wraps modulo 2^WIDTH.
- Output registers and out_valid are stable while out_valid && !out_ready, with no change at all.
- Inputs are ignored when not firing; in_* may change freely outside fire.
- Reset (any state, including mid-EXEC or DONE):
  - state=IDLE, out_valid=0, all out_* regs = 0, latches = 0.
  - in_ready=1 in the cycle after the reset edge, even if an in-flight result is lost.
- rd==0: out_wen=0 regardless of in_wen; out_result is still computed.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined:
  - Adds outputs perf_ops[31:0] (+1 per out fire) and perf_stall[31:0] (+1 per cycle with out_valid && !out_ready).
  - Both counters wrap at 2^32 and reset to 0 on rst_n low.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Add: rs1=5, rs2=7, op=00, opa/opb=0, rd=3, wen=1, out_ready=1 → out_valid 2 cycles after fire; out_result=12, out_wen=1, out_rd=3, out_zero=0.
- jalr: rs1=0x80000101, imm=4, opb_sel=1, op=10, link=1, pc=0x80000010 → out_target=0x80000104, out_result=0x80000014.
- Subtract equal: rs1=rs2=0x1234, op=11 → out_zero=1, out_target=0. Same test with rd=0, wen=1 → out_wen=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid held 1 with a new instruction:
  - outputs frozen and in_ready=0 throughout;
  - on out_ready=1 the next instruction fires the same cycle;
  - its result appears 2 cycles later;
  - with ALU_ISSUE_PERF_EN: perf_stall=5, perf_ops=2.
- Reset mid-op: rst_n=0 during EXEC → next cycle out_valid=0, in_ready=1, out_result=0, alu_op=00; no stale result is ever emitted.
- Wrap: pc=0xFFFFFFFC, link=1 → out_result=0x00000000.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Execute-stage sequencer that drives an external combinational ALU.
// Accepts one decoded instruction from the IDU (valid/ready), latches its
// operands, presents them to the ALU for one cycle, captures the ALU result
// and offers the registered writeback bundle to the WBU (valid/ready).
//
// ALU opcode encoding (forwarded unchanged):
//   00 add, 01 pass-B, 10 add-and-clear-bit0, 11 subtract
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   IDU handshake
//   in_pc, in_rs1/2     instruction PC and register source values
//   in_imm              sign-extended immediate
//   in_opa_sel          0: A=rs1, 1: A=pc
//   in_opb_sel          0: B=rs2, 1: B=imm
//   in_alu_op           ALU opcode
//   in_rd, in_wen       destination index and write enable
//   in_link             writeback value is pc+4 (jal/jalr)
//   alu_a/alu_b/alu_op  ALU operand/opcode drive (zero outside EXEC)
//   alu_out             combinational ALU result
//   out_valid/out_ready WBU handshake
//   out_result          writeback value
//   out_target          raw ALU result (jump target / address)
//   out_zero            ALU result was zero at capture
//   out_rd, out_wen     destination index, write enable (0 when rd==0)
//
// Optional feature (macro ALU_ISSUE_PERF_EN):
//   perf_ops   [31:0]   +1 per output handshake
//   perf_stall [31:0]   +1 per cycle with out_valid && !out_ready
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_opa_sel,
  input  logic             in_opb_sel,
  input  logic [1:0]       in_alu_op,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  input  logic             in_link,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_target,
  output logic             out_zero,
  output logic [4:0]       out_rd,
  output logic             out_wen
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic fire_in;
  logic fire_out;

  // Link address: pc+4, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] link_addr(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(4);
  endfunction

  // Operand latch stage
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [1:0]       op_p0;
  logic [WIDTH-1:0] pc_p0;
  logic             link_p0;
  logic [4:0]       rd_p0;
  logic             wen_p0;

  // Result capture stage
  logic [WIDTH-1:0] result_p1;
  logic [WIDTH-1:0] target_p1;
  logic             zero_p1;
  logic [4:0]       rd_p1;
  logic             wen_p1;

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
    fire_in   = in_valid && in_ready;
    fire_out  = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (fire_in) state_d = S_EXEC;
      S_EXEC: state_d = S_DONE;
      // A waiting instruction is accepted in the same cycle the result leaves.
      S_DONE: if (out_ready) state_d = in_valid ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // The ALU only sees live operands while the instruction is executing.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 2'b00;
    if (state_q == S_EXEC) begin
      alu_a  = a_p0;
      alu_b  = b_p0;
      alu_op = op_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p0    <= '0;
      b_p0    <= '0;
      op_p0   <= 2'b00;
      pc_p0   <= '0;
      link_p0 <= 1'b0;
      rd_p0   <= 5'd0;
      wen_p0  <= 1'b0;
    end else if (fire_in) begin
      a_p0    <= in_opa_sel ? in_pc  : in_rs1;
      b_p0    <= in_opb_sel ? in_imm : in_rs2;
      op_p0   <= in_alu_op;
      pc_p0   <= in_pc;
      link_p0 <= in_link;
      rd_p0   <= in_rd;
      wen_p0  <= in_wen;
    end
  end

  // Capture holds its value through DONE, so a stalled result never moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_p1 <= '0;
      target_p1 <= '0;
      zero_p1   <= 1'b0;
      rd_p1     <= 5'd0;
      wen_p1    <= 1'b0;
    end else if (state_q == S_EXEC) begin
      result_p1 <= link_p0 ? link_addr(pc_p0) : alu_out;
      target_p1 <= alu_out;
      zero_p1   <= (alu_out == '0);
      rd_p1     <= rd_p0;
      wen_p1    <= wen_p0 && (rd_p0 != 5'd0);
    end
  end

  assign out_result = result_p1;
  assign out_target = target_p1;
  assign out_zero   = zero_p1;
  assign out_rd     = rd_p1;
  assign out_wen    = wen_p1;

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops   <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      if (fire_out)               perf_ops   <= perf_ops + 32'd1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. The bench plays the ALU and keeps a
// transaction-level reference: each accepted instruction becomes a queue entry
// carrying its expected ALU drive, its expected writeback bundle and the cycle
// at which it must become visible. Directed cases first, then random traffic.
// ----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic        in_opa_sel, in_opb_sel;
  logic [1:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic        in_wen, in_link;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_op;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_target;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_wen;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_opa_sel(in_opa_sel), .in_opb_sel(in_opb_sel), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_wen(in_wen), .in_link(in_link),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_target(out_target), .out_zero(out_zero),
    .out_rd(out_rd), .out_wen(out_wen)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return b;
      2'b10:   return (a + b) & 32'hFFFF_FFFE;
      default: return a - b;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_op);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [31:0] result, target;
    logic        zero;
    logic [4:0]  rd;
    logic        wen;
    int          ready_at;
  } item_t;

  item_t q[$];
  item_t it;
  int    cyc = 0;
  bit    vis, exe, exp_rdy;
  logic [31:0] r;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] m_ops = 0, m_stall = 0;
`endif

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
`ifdef ALU_ISSUE_PERF_EN
      m_ops = 0;
      m_stall = 0;
`endif
    end else begin
      vis     = (q.size() > 0) && (cyc >= q[0].ready_at);
      exe     = (q.size() > 0) && (cyc == q[0].ready_at - 1);
      exp_rdy = (q.size() == 0) || (vis && out_ready);
      check_eq("out_valid", out_valid, vis);
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("alu_a", alu_a, exe ? q[0].a : 32'd0);
      check_eq("alu_b", alu_b, exe ? q[0].b : 32'd0);
      check_eq("alu_op", alu_op, exe ? q[0].op : 2'b00);
      if (vis) begin
        check_eq("out_result", out_result, q[0].result);
        check_eq("out_target", out_target, q[0].target);
        check_eq("out_zero", out_zero, q[0].zero);
        check_eq("out_rd", out_rd, q[0].rd);
        check_eq("out_wen", out_wen, q[0].wen);
      end
`ifdef ALU_ISSUE_PERF_EN
      check_eq("perf_ops", perf_ops, m_ops);
      check_eq("perf_stall", perf_stall, m_stall);
      if (vis && !out_ready) m_stall = m_stall + 1;
      if (vis && out_ready)  m_ops = m_ops + 1;
`endif
      if (vis && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        it.a        = in_opa_sel ? in_pc : in_rs1;
        it.b        = in_opb_sel ? in_imm : in_rs2;
        it.op       = in_alu_op;
        r           = alu_ref(it.a, it.b, it.op);
        it.target   = r;
        it.zero     = (r == 32'd0);
        it.result   = in_link ? in_pc + 32'd4 : r;
        it.rd       = in_rd;
        it.wen      = in_wen && (in_rd != 5'd0);
        it.ready_at = cyc + 2;
        q.push_back(it);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_instr(input logic [31:0] pc, rs1, rs2, imm, input logic opa, opb,
                           input logic [1:0] op, input logic [4:0] rd,
                           input logic wen, link);
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_opa_sel = opa; in_opb_sel = opb; in_alu_op = op;
    in_rd = rd; in_wen = wen; in_link = link;
  endtask

  // Returns #1 after the accepting edge, i.e. inside the EXEC cycle.
  task automatic issue(input logic [31:0] pc, rs1, rs2, imm, input logic opa, opb,
                       input logic [1:0] op, input logic [4:0] rd,
                       input logic wen, link);
    @(posedge clk); #1;
    set_instr(pc, rs1, rs2, imm, opa, opb, op, rd, wen, link);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check_eq("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);

    // Add: 5 + 7 -> 12
    issue(32'h0, 32'd5, 32'd7, 32'd0, 0, 0, 2'b00, 5'd3, 1, 0);
    @(negedge clk);
    check_eq("add_lat_exec", out_valid, 1'b0);
    @(negedge clk);
    check_eq("add_valid", out_valid, 1'b1);
    check_eq("add_result", out_result, 32'd12);
    check_eq("add_wen", out_wen, 1'b1);
    check_eq("add_rd", out_rd, 5'd3);
    check_eq("add_zero", out_zero, 1'b0);

    // jalr
    issue(32'h8000_0010, 32'h8000_0101, 32'd0, 32'd4, 0, 1, 2'b10, 5'd1, 1, 1);
    repeat (2) @(negedge clk);
    check_eq("jalr_target", out_target, 32'h8000_0104);
    check_eq("jalr_result", out_result, 32'h8000_0014);

    // Subtract equal, then again with rd=0
    issue(32'h0, 32'h1234, 32'h1234, 32'd0, 0, 0, 2'b11, 5'd5, 1, 0);
    repeat (2) @(negedge clk);
    check_eq("sub_zero", out_zero, 1'b1);
    check_eq("sub_target", out_target, 32'd0);
    issue(32'h0, 32'h1234, 32'h1234, 32'd0, 0, 0, 2'b11, 5'd0, 1, 0);
    repeat (2) @(negedge clk);
    check_eq("rd0_wen", out_wen, 1'b0);
    check_eq("rd0_zero", out_zero, 1'b1);

    // pc+4 wraps
    issue(32'hFFFF_FFFC, 32'd9, 32'd9, 32'd0, 0, 0, 2'b00, 5'd2, 1, 1);
    repeat (2) @(negedge clk);
    check_eq("wrap_result", out_result, 32'h0000_0000);
    check_eq("wrap_target", out_target, 32'd18);

    // Backpressure with a second instruction waiting
    pulse_reset();
    out_ready = 1'b0;
    issue(32'h0, 32'd1, 32'd2, 32'd0, 0, 0, 2'b00, 5'd4, 1, 0);
    set_instr(32'h0, 32'd100, 32'd30, 32'd0, 0, 0, 2'b11, 5'd6, 1, 0);
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("bp_exec_ready", in_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_ready", in_ready, 1'b0);
      check_eq("bp_valid", out_valid, 1'b1);
      check_eq("bp_frozen", out_result, 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_same_cycle_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_b_exec", out_valid, 1'b0);
    @(negedge clk);
    check_eq("bp_b_valid", out_valid, 1'b1);
    check_eq("bp_b_result", out_result, 32'd70);
    @(negedge clk);
`ifdef ALU_ISSUE_PERF_EN
    check_eq("bp_perf_stall", perf_stall, 32'd5);
    check_eq("bp_perf_ops", perf_ops, 32'd2);
`endif

    // Reset while executing
    issue(32'h0, 32'd11, 32'd22, 32'd0, 0, 0, 2'b11, 5'd7, 1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_valid", out_valid, 1'b0);
    check_eq("rst_mid_ready", in_ready, 1'b1);
    check_eq("rst_mid_result", out_result, 32'd0);
    check_eq("rst_mid_aluop", alu_op, 2'b00);
    repeat (3) @(negedge clk);
    check_eq("rst_no_stale", out_valid, 1'b0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      set_instr(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        in_alu_op = 2'b11;
        in_opa_sel = 1'b0; in_opb_sel = 1'b0;
        in_rs2 = in_rs1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
